booth_multiplier: RTL and testbench

Sequential signed radix-2 Booth multiplier for the arithmetic datapath. It is the multiply-side counterpart of the restoring divider. It shares the same add/subtract-and-shift style: one Booth step per clock, with an accumulator that is conditionally added to or subtracted from. It sits beside the divider as an iterative functional unit and is driven by a start/done handshake from the controller.

---
 rtl/booth_multiplier.sv | 108 ++++++++++
 tb/tb_booth_multiplier.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_multiplier.sv
// Sequential signed radix-2 Booth multiplier: one add/subtract-and-shift step per clock,
// start/done handshake, N-cycle latency from the accepting edge.
module booth_multiplier #(
    parameter int unsigned N = 7
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    output logic [2*N-1:0] product,
    output logic           busy,
    output logic           done
);

    localparam int unsigned CW = $clog2(N) + 1;
    localparam logic [N:0] OneA = (N+1)'(1);
    localparam logic [CW-1:0] LastStep = CW'(N - 1);

    typedef enum logic {StIdle, StCalc} state_e;

    state_e          state_q, state_d;
    logic [N:0]      m_q, m_d;
    logic [N:0]      a_q, a_d;
    logic [N-1:0]    q_q, q_d;
    logic            q1_q, q1_d;
    logic [CW-1:0]   count_q, count_d;
    logic [2*N-1:0]  product_q, product_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [N:0]      sum;

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        a_d       = a_q;
        q_d       = q_q;
        q1_d      = q1_q;
        count_d   = count_q;
        product_d = product_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        sum       = a_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    m_d     = {multiplicand[N-1], multiplicand};
                    q_d     = multiplier;
                    a_d     = '0;
                    q1_d    = 1'b0;
                    count_d = '0;
                    busy_d  = 1'b1;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                case ({q_q[0], q1_q})
                    2'b01:   sum = a_q + m_q;
                    2'b10:   sum = a_q + ~m_q + OneA;
                    default: sum = a_q;
                endcase
                // Arithmetic right shift of {A', Q, Q_1}.
                a_d     = {sum[N], sum[N:1]};
                q_d     = {sum[0], q_q[N-1:1]};
                q1_d    = q_q[0];
                count_d = count_q + CW'(1);
                if (count_q == LastStep) begin
                    // Final {A, Q} always fits in 2N signed bits, so A's guard bit is dropped.
                    product_d = {a_d[N-1:0], q_d};
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            m_q       <= '0;
            a_q       <= '0;
            q_q       <= '0;
            q1_q      <= 1'b0;
            count_q   <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            a_q       <= a_d;
            q_q       <= q_d;
            q1_q      <= q1_d;
            count_q   <= count_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign product = product_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_booth_multiplier.sv
// Directed bench for booth_multiplier (N = 7): handshake timing, guard bit, back-to-back,
// ignored start, asynchronous abort and a signed operand sweep.
module tb_booth_multiplier;

    localparam int unsigned N = 7;

    logic           clk;
    logic           rst;
    logic           start;
    logic [N-1:0]   multiplicand;
    logic [N-1:0]   multiplier;
    logic [2*N-1:0] product;
    logic           busy;
    logic           done;

    int n_checks = 0;
    int n_fails  = 0;

    booth_multiplier #(.N(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .product      (product),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch one operation and wait (bounded) for done; returns the product and the latency.
    task automatic run_op(input logic [N-1:0] m, input logic [N-1:0] q,
                          output logic [2*N-1:0] prod, output int lat);
        multiplicand = m;
        multiplier   = q;
        start        = 1'b1;
        step();
        start = 1'b0;
        lat   = 0;
        while (done !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        prod = product;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; multiplicand = '0; multiplier = '0;
        step();
        step();
        n_checks++;
        if (product !== 14'h0000) begin
            n_fails++; $display("FAIL reset_product: got %h want 0000", product);
        end
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fails++; $display("FAIL reset_flags: got busy=%b done=%b want 0 0", busy, done);
        end
        #3 rst = 1'b1;
        step();
    endtask

    task automatic test_basic();
        int lat = 0;
        int bc  = 0;
        multiplicand = 7'd3;
        multiplier   = 7'd5;
        start        = 1'b1;
        step();
        start = 1'b0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) bc++;
            step();
            lat++;
        end
        n_checks++;
        if (lat != 7) begin n_fails++; $display("FAIL basic_latency: got %0d want 7", lat); end
        n_checks++;
        if (bc != 7) begin n_fails++; $display("FAIL basic_busy_cycles: got %0d want 7", bc); end
        n_checks++;
        if (busy !== 1'b0) begin n_fails++; $display("FAIL basic_busy_at_done: got %b want 0", busy); end
        n_checks++;
        if (product !== 14'h000F) begin
            n_fails++; $display("FAIL basic_product: got %h want 000f", product);
        end
        step();
        n_checks++;
        if (done !== 1'b0) begin n_fails++; $display("FAIL basic_done_pulse: got %b want 0", done); end
        step();
    endtask

    task automatic test_guard();
        logic [2*N-1:0] p;
        int lat;
        run_op(7'h40, 7'h40, p, lat);
        n_checks++;
        if (p !== 14'h1000 || lat != 7) begin
            n_fails++; $display("FAIL guard_product: got %h lat %0d want 1000 lat 7", p, lat);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [2*N-1:0] p;
        int lat;
        run_op(7'h40, 7'h3F, p, lat);
        n_checks++;
        if (p !== 14'h3040) begin n_fails++; $display("FAIL b2b_first: got %h want 3040", p); end
        // Still in the done cycle: the next start must be accepted at the coming edge.
        multiplicand = 7'd0;
        multiplier   = 7'h6F;
        start        = 1'b1;
        step();
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fails++; $display("FAIL b2b_accept: got busy=%b done=%b want 1 0", busy, done);
        end
        n_checks++;
        if (product !== 14'h3040) begin
            n_fails++; $display("FAIL b2b_held: got %h want 3040", product);
        end
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin step(); lat++; end
        n_checks++;
        if (product !== 14'h0000 || lat != 7) begin
            n_fails++; $display("FAIL b2b_second: got %h lat %0d want 0000 lat 7", product, lat);
        end
        step();
    endtask

    task automatic test_ignore_start();
        int ndone = 0;
        multiplicand = 7'd7;
        multiplier   = 7'd9;
        start        = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        multiplicand = 7'd2;
        multiplier   = 7'd2;
        start        = 1'b1;
        step();
        start        = 1'b0;
        multiplicand = 7'h55;
        multiplier   = 7'h2A;
        for (int i = 0; i < 20; i++) begin
            if (done === 1'b1) begin
                ndone++;
                n_checks++;
                if (product !== 14'd63) begin
                    n_fails++; $display("FAIL ignore_product: got %h want 003f", product);
                end
            end
            step();
        end
        n_checks++;
        if (ndone != 1) begin n_fails++; $display("FAIL ignore_done_count: got %0d want 1", ndone); end
    endtask

    task automatic test_reset_mid();
        logic [2*N-1:0] p;
        int lat;
        int ndone = 0;
        multiplicand = 7'd5;
        multiplier   = 7'd5;
        start        = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 14'h0000) begin
            n_fails++;
            $display("FAIL abort_immediate: got busy=%b done=%b prod=%h want 0 0 0000",
                     busy, done, product);
        end
        @(posedge clk);
        #3 rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done === 1'b1) ndone++;
        end
        n_checks++;
        if (ndone != 0 || product !== 14'h0000) begin
            n_fails++; $display("FAIL abort_no_done: got %0d dones prod=%h want 0 0000", ndone, product);
        end
        run_op(7'h7F, 7'h7F, p, lat);
        n_checks++;
        if (p !== 14'h0001 || lat != 7) begin
            n_fails++; $display("FAIL abort_restart: got %h lat %0d want 0001 lat 7", p, lat);
        end
        step();
    endtask

    task automatic test_sweep();
        logic signed [N-1:0]   ms;
        logic signed [N-1:0]   qs;
        logic [2*N-1:0]        p;
        logic [2*N-1:0]        exp_p;
        int                    lat;
        logic [N-1:0]          corner [6];
        corner[0] = 7'h40; corner[1] = 7'h41; corner[2] = 7'h7F;
        corner[3] = 7'h00; corner[4] = 7'h01; corner[5] = 7'h3F;
        for (int mi = -64; mi < 64; mi++) begin
            for (int j = 0; j < 12; j++) begin
                ms = 7'(mi);
                qs = (j < 6) ? $signed(corner[j]) : $signed(7'($urandom_range(0, 127)));
                exp_p = (2*N)'(int'(ms) * int'(qs));
                run_op(ms, qs, p, lat);
                n_checks++;
                if (p !== exp_p || lat != 7 || busy !== 1'b0) begin
                    n_fails++;
                    $display("FAIL sweep %0d*%0d: got %h lat %0d busy %b want %h lat 7 busy 0",
                             ms, qs, p, lat, busy, exp_p);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_guard();
        test_back_to_back();
        test_ignore_start();
        test_reset_mid();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
